// File: rtl/rs_pkg.sv
// Shared defaults and helpers for the age-ordered reservation station.
package rs_pkg;

  localparam int RS_DEPTH_DEF  = 16;
  localparam int CDB_PORTS_DEF = 2;
  localparam int ROB_IDX_W_DEF = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int OP_W_DEF      = 6;
  localparam int OPT_W_DEF     = 7;

  // LSB position of one port's field inside a packed CDB bus (port 0 in the LSBs).
  function automatic int cdb_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// Picks the oldest ready entry from an age matrix.
// age_i[i][j] = 1 means entry i is older than entry j. If the matrix is
// inconsistent (no unique winner), the lowest-index candidate is taken.
module rs_oldest_select #(
  parameter int RS_DEPTH = 16
) (
  input  logic [RS_DEPTH-1:0]               ready_i,
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_i,
  output logic [RS_DEPTH-1:0]               grant_o,
  output logic [$clog2(RS_DEPTH)-1:0]       idx_o,
  output logic                              found_o
);

  localparam int IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0] wins;
  logic [RS_DEPTH-1:0] cand;

  // An entry wins when it is ready and older than every other ready entry.
  always_comb begin
    wins = ready_i;
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (i != j && ready_i[j] && !age_i[i][j]) begin
          wins[i] = 1'b0;
        end
      end
    end
  end

  // Reduce the candidates to a single lowest-index grant.
  always_comb begin
    cand    = (|wins) ? wins : ready_i;
    grant_o = '0;
    idx_o   = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IDX_W'(i);
      end
    end
    found_o = |ready_i;
  end

endmodule

// File: rtl/rs_age_cdb.sv
// Reservation station for the ALU: holds issued ops, wakes operands from the
// CDB, and hands the oldest ready op to a back-pressured dispatch register.
module rs_age_cdb
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = RS_DEPTH_DEF,
  parameter int CDB_PORTS = CDB_PORTS_DEF,
  parameter int ROB_IDX_W = ROB_IDX_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int OP_W      = OP_W_DEF,
  parameter int OPT_W     = OPT_W_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          clr_in,
  input  logic                          issue_valid,
  input  logic [ROB_IDX_W-1:0]          issue_rob_index,
  input  logic [OP_W-1:0]               issue_op,
  input  logic [OPT_W-1:0]              issue_op_type,
  input  logic [DATA_W-1:0]             issue_rs1_val,
  input  logic [DATA_W-1:0]             issue_rs2_val,
  input  logic                          issue_rs1_dep,
  input  logic                          issue_rs2_dep,
  input  logic [ROB_IDX_W-1:0]          issue_rs1_tag,
  input  logic [ROB_IDX_W-1:0]          issue_rs2_tag,
  input  logic [DATA_W-1:0]             issue_imm,
  input  logic [DATA_W-1:0]             issue_pc,
  input  logic [CDB_PORTS-1:0]          cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_W-1:0] cdb_tag,
  input  logic [CDB_PORTS*DATA_W-1:0]   cdb_data,
  output logic                          disp_valid,
  input  logic                          disp_ready,
  output logic [OP_W-1:0]               disp_op,
  output logic [OPT_W-1:0]              disp_op_type,
  output logic [DATA_W-1:0]             disp_rs1,
  output logic [DATA_W-1:0]             disp_rs2,
  output logic [DATA_W-1:0]             disp_imm,
  output logic [DATA_W-1:0]             disp_pc,
  output logic [ROB_IDX_W-1:0]          disp_rob_index,
  output logic                          rs_full,
  output logic [$clog2(RS_DEPTH):0]     rs_count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0]    val;
    logic                 dep;
    logic [ROB_IDX_W-1:0] tag;
  } opnd_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [OP_W-1:0]      op;
    logic [OPT_W-1:0]     op_type;
    opnd_t                rs1;
    opnd_t                rs2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
  } entry_t;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] rob;
    logic [OP_W-1:0]      op;
    logic [OPT_W-1:0]     op_type;
    logic [DATA_W-1:0]    rs1;
    logic [DATA_W-1:0]    rs2;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    pc;
  } disp_t;

  entry_t                           ent_q [RS_DEPTH];
  entry_t                           ent_d [RS_DEPTH];
  logic [RS_DEPTH-1:0]              busy_q, busy_d;
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
  disp_t                            disp_q, disp_d;
  logic                             disp_valid_q, disp_valid_d;
  logic [CNT_W-1:0]                 rs_count_q, rs_count_d;

  logic [ROB_IDX_W-1:0] cdb_tag_w  [CDB_PORTS];
  logic [DATA_W-1:0]    cdb_data_w [CDB_PORTS];

  logic [RS_DEPTH-1:0]  ready;
  logic [RS_DEPTH-1:0]  sel_grant;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_found;
  logic [IDX_W-1:0]     free_idx;
  logic                 issue_acc;
  logic                 load_en;
  logic                 free_en;
  entry_t               new_ent;

  // Unpack the CDB buses into per-port tag/data.
  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      cdb_tag_w[p]  = cdb_tag[cdb_lsb(p, ROB_IDX_W) +: ROB_IDX_W];
      cdb_data_w[p] = cdb_data[cdb_lsb(p, DATA_W) +: DATA_W];
    end
  end

  // Capture a pending operand from the CDB; walking ports downward lets the lowest port win.
  function automatic opnd_t wake(input opnd_t o);
    opnd_t r;
    r = o;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (o.dep && cdb_valid[p] && cdb_tag_w[p] == o.tag) begin
        r.val = cdb_data_w[p];
        r.dep = 1'b0;
      end
    end
    return r;
  endfunction

  // Ready and free-slot choice look only at registered state.
  always_comb begin
    free_idx = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready[i] = busy_q[i] && !ent_q[i].rs1.dep && !ent_q[i].rs2.dep;
    end
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  rs_oldest_select #(
    .RS_DEPTH (RS_DEPTH)
  ) u_select (
    .ready_i  (ready),
    .age_i    (age_q),
    .grant_o  (sel_grant),
    .idx_o    (sel_idx),
    .found_o  (sel_found)
  );

  assign rs_full   = (rs_count_q == CNT_W'(RS_DEPTH));
  assign issue_acc = issue_valid && !rs_full;
  assign load_en   = !disp_valid_q || disp_ready;
  assign free_en   = load_en && sel_found;

  // Build the incoming entry, checking its operands against this cycle's CDB.
  always_comb begin
    new_ent.rob     = issue_rob_index;
    new_ent.op      = issue_op;
    new_ent.op_type = issue_op_type;
    new_ent.rs1     = wake('{val: issue_rs1_val, dep: issue_rs1_dep, tag: issue_rs1_tag});
    new_ent.rs2     = wake('{val: issue_rs2_val, dep: issue_rs2_dep, tag: issue_rs2_tag});
    new_ent.imm     = issue_imm;
    new_ent.pc      = issue_pc;
  end

  // Next state: dispatch load, wakeup of waiting entries, issue and age update.
  always_comb begin
    disp_d       = disp_q;
    disp_valid_d = disp_valid_q;
    busy_d       = busy_q;
    ent_d        = ent_q;
    age_d        = age_q;

    if (load_en) begin
      disp_valid_d = sel_found;
      if (sel_found) begin
        disp_d.rob     = ent_q[sel_idx].rob;
        disp_d.op      = ent_q[sel_idx].op;
        disp_d.op_type = ent_q[sel_idx].op_type;
        disp_d.rs1     = ent_q[sel_idx].rs1.val;
        disp_d.rs2     = ent_q[sel_idx].rs2.val;
        disp_d.imm     = ent_q[sel_idx].imm;
        disp_d.pc      = ent_q[sel_idx].pc;
        busy_d         = busy_q & ~sel_grant;
      end
    end

    for (int i = 0; i < RS_DEPTH; i++) begin
      if (busy_q[i]) begin
        ent_d[i].rs1 = wake(ent_q[i].rs1);
        ent_d[i].rs2 = wake(ent_q[i].rs2);
      end
    end

    if (issue_acc) begin
      busy_d[free_idx] = 1'b1;
      ent_d[free_idx]  = new_ent;
      age_d[free_idx]  = '0;
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (busy_q[j]) begin
          age_d[j][free_idx] = 1'b1;
        end
      end
    end
  end

  assign rs_count_d = rs_count_q + CNT_W'(issue_acc) - CNT_W'(free_en);

  // State registers: reset/flush dominate, rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q       <= '0;
      age_q        <= '0;
      disp_q       <= '0;
      disp_valid_q <= 1'b0;
      rs_count_q   <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else if (clr_in) begin
      busy_q       <= '0;
      age_q        <= '0;
      disp_valid_q <= 1'b0;
      rs_count_q   <= '0;
    end else if (rdy_in) begin
      busy_q       <= busy_d;
      age_q        <= age_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      rs_count_q   <= rs_count_d;
      ent_q        <= ent_d;
    end
  end

  assign disp_valid     = disp_valid_q;
  assign disp_op        = disp_q.op;
  assign disp_op_type   = disp_q.op_type;
  assign disp_rs1       = disp_q.rs1;
  assign disp_rs2       = disp_q.rs2;
  assign disp_imm       = disp_q.imm;
  assign disp_pc        = disp_q.pc;
  assign disp_rob_index = disp_q.rob;
  assign rs_count       = rs_count_q;

endmodule

// File: tb/tb_rs_age_cdb.sv
// Bench for rs_age_cdb: queue-based reference model (oldest-first list of
// waiting ops) checked every cycle, plus directed scenarios with literal expectations.
module tb_rs_age_cdb;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        issue_valid;
  logic [3:0]  issue_rob_index;
  logic [5:0]  issue_op;
  logic [6:0]  issue_op_type;
  logic [31:0] issue_rs1_val, issue_rs2_val;
  logic        issue_rs1_dep, issue_rs2_dep;
  logic [3:0]  issue_rs1_tag, issue_rs2_tag;
  logic [31:0] issue_imm, issue_pc;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        disp_valid, disp_ready;
  logic [5:0]  disp_op;
  logic [6:0]  disp_op_type;
  logic [31:0] disp_rs1, disp_rs2, disp_imm, disp_pc;
  logic [3:0]  disp_rob_index;
  logic        rs_full;
  logic [4:0]  rs_count;

  always #5 clk_in = ~clk_in;

  rs_age_cdb dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .clr_in          (clr_in),
    .issue_valid     (issue_valid),
    .issue_rob_index (issue_rob_index),
    .issue_op        (issue_op),
    .issue_op_type   (issue_op_type),
    .issue_rs1_val   (issue_rs1_val),
    .issue_rs2_val   (issue_rs2_val),
    .issue_rs1_dep   (issue_rs1_dep),
    .issue_rs2_dep   (issue_rs2_dep),
    .issue_rs1_tag   (issue_rs1_tag),
    .issue_rs2_tag   (issue_rs2_tag),
    .issue_imm       (issue_imm),
    .issue_pc        (issue_pc),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_op         (disp_op),
    .disp_op_type    (disp_op_type),
    .disp_rs1        (disp_rs1),
    .disp_rs2        (disp_rs2),
    .disp_imm        (disp_imm),
    .disp_pc         (disp_pc),
    .disp_rob_index  (disp_rob_index),
    .rs_full         (rs_full),
    .rs_count        (rs_count)
  );

  typedef struct {
    logic [3:0]  rob;
    logic [5:0]  op;
    logic [6:0]  opt;
    logic [31:0] v1, v2;
    bit          d1, d2;
    logic [3:0]  t1, t2;
    logic [31:0] imm, pc;
  } ent_t;

  typedef struct {
    logic [3:0]  rob;
    logic [5:0]  op;
    logic [31:0] rs1, rs2;
    int          cyc;
  } log_t;

  ent_t mq[$];
  ent_t m_d;
  bit   m_dv;
  bit   chk_en = 1'b0;
  int   cyc = 0;
  log_t lg[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t zero_ent();
    ent_t e;
    e.rob = '0; e.op = '0; e.opt = '0; e.v1 = '0; e.v2 = '0;
    e.d1 = 1'b0; e.d2 = 1'b0; e.t1 = '0; e.t2 = '0; e.imm = '0; e.pc = '0;
    return e;
  endfunction

  function automatic ent_t wake(input ent_t e_in);
    ent_t e;
    e = e_in;
    for (int p = 0; p < 2; p++) begin
      if (e.d1 && cdb_valid[p] && cdb_tag[p*4 +: 4] == e.t1) begin
        e.v1 = cdb_data[p*32 +: 32];
        e.d1 = 1'b0;
      end
      if (e.d2 && cdb_valid[p] && cdb_tag[p*4 +: 4] == e.t2) begin
        e.v2 = cdb_data[p*32 +: 32];
        e.d2 = 1'b0;
      end
    end
    return e;
  endfunction

  // Reference model: waiting ops kept oldest-first; dispatch takes the first ready one.
  always @(posedge clk_in) begin : model
    int   pick;
    bit   acc;
    ent_t ne;
    cyc = cyc + 1;
    if (rst_in) begin
      mq.delete();
      m_dv   = 1'b0;
      m_d    = zero_ent();
      chk_en = 1'b1;
    end else if (clr_in) begin
      mq.delete();
      m_dv = 1'b0;
    end else if (rdy_in) begin
      acc = issue_valid && (mq.size() < 16);
      if (!m_dv || disp_ready) begin
        pick = -1;
        for (int i = 0; i < mq.size(); i++) begin
          if (pick < 0 && !mq[i].d1 && !mq[i].d2) pick = i;
        end
        if (pick >= 0) begin
          m_d  = mq[pick];
          mq.delete(pick);
          m_dv = 1'b1;
        end else begin
          m_dv = 1'b0;
        end
      end
      for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
      if (acc) begin
        ne.rob = issue_rob_index; ne.op = issue_op; ne.opt = issue_op_type;
        ne.v1 = issue_rs1_val; ne.d1 = issue_rs1_dep; ne.t1 = issue_rs1_tag;
        ne.v2 = issue_rs2_val; ne.d2 = issue_rs2_dep; ne.t2 = issue_rs2_tag;
        ne.imm = issue_imm; ne.pc = issue_pc;
        mq.push_back(wake(ne));
      end
    end
  end

  // Compare every cycle and log completed handshakes.
  always @(negedge clk_in) begin
    if (chk_en) begin
      chk("rs_count", 64'(rs_count), 64'(mq.size()));
      chk("rs_full", 64'(rs_full), 64'(mq.size() == 16));
      chk("disp_valid", 64'(disp_valid), 64'(m_dv));
      chk("disp_rob", 64'(disp_rob_index), 64'(m_d.rob));
      chk("disp_op", 64'(disp_op), 64'(m_d.op));
      chk("disp_op_type", 64'(disp_op_type), 64'(m_d.opt));
      chk("disp_rs1", 64'(disp_rs1), 64'(m_d.v1));
      chk("disp_rs2", 64'(disp_rs2), 64'(m_d.v2));
      chk("disp_imm", 64'(disp_imm), 64'(m_d.imm));
      chk("disp_pc", 64'(disp_pc), 64'(m_d.pc));
      if (disp_valid && disp_ready && rdy_in && !rst_in && !clr_in)
        lg.push_back('{rob: disp_rob_index, op: disp_op, rs1: disp_rs1, rs2: disp_rs2, cyc: cyc});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = '0;
    clr_in      = 1'b0;
  endtask

  task automatic set_issue(input logic [3:0] rob, input logic [5:0] op,
                           input logic [31:0] v1, input bit d1, input logic [3:0] t1,
                           input logic [31:0] v2, input bit d2, input logic [3:0] t2);
    issue_valid     = 1'b1;
    issue_rob_index = rob;
    issue_op        = op;
    issue_op_type   = {1'b1, op};
    issue_rs1_val   = v1; issue_rs1_dep = d1; issue_rs1_tag = t1;
    issue_rs2_val   = v2; issue_rs2_dep = d2; issue_rs2_tag = t2;
    issue_imm       = {26'h0, op} ^ 32'h0F0F_0000;
    issue_pc        = 32'h0000_1000 + ({26'h0, op} << 2);
  endtask

  task automatic set_cdb(input int port, input logic [3:0] tag, input logic [31:0] data);
    cdb_valid[port]          = 1'b1;
    cdb_tag[port*4 +: 4]     = tag;
    cdb_data[port*32 +: 32]  = data;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    step(2);
    rst_in = 1'b0;
  endtask

  task automatic run_scen(input bit stall);
    do_reset();
    lg.delete();
    rdy_in     = 1'b1;
    disp_ready = 1'b1;
    set_issue(4'd1, 6'd20, 32'hAAAA, 1'b1, 4'd3, 32'h2, 1'b0, 4'd0);
    step(1);
    set_issue(4'd2, 6'd21, 32'h21, 1'b0, 4'd0, 32'h22, 1'b0, 4'd0);
    step(1);
    if (stall) begin
      rdy_in = 1'b0;
      set_issue(4'd7, 6'd30, 32'h30, 1'b0, 4'd0, 32'h31, 1'b0, 4'd0);
      set_cdb(0, 4'd3, 32'h99);
      for (int k = 0; k < 4; k++) begin
        step(1);
        chk("stall_count", 64'(rs_count), 64'd2);
        chk("stall_disp_valid", 64'(disp_valid), 64'd0);
      end
      rdy_in = 1'b1;
    end
    idle();
    set_cdb(0, 4'd3, 32'h33);
    step(1);
    idle();
    step(4);
    chk("scen_log_size", 64'(lg.size()), 64'd2);
    if (lg.size() >= 2) begin
      chk("scen_first_op", 64'(lg[0].op), 64'd21);
      chk("scen_second_op", 64'(lg[1].op), 64'd20);
      chk("scen_second_rs1", 64'(lg[1].rs1), 64'h33);
      chk("scen_spacing", 64'(lg[1].cyc - lg[0].cyc), 64'd1);
    end
  endtask

  initial begin
    int t_cdb;
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; disp_ready = 1'b1;
    issue_valid = 1'b0; issue_rob_index = '0; issue_op = '0; issue_op_type = '0;
    issue_rs1_val = '0; issue_rs2_val = '0; issue_rs1_dep = 1'b0; issue_rs2_dep = 1'b0;
    issue_rs1_tag = '0; issue_rs2_tag = '0; issue_imm = '0; issue_pc = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    step(2);
    rst_in = 1'b0;
    chk("reset_count", 64'(rs_count), 64'd0);
    chk("reset_full", 64'(rs_full), 64'd0);
    chk("reset_disp_valid", 64'(disp_valid), 64'd0);
    chk("reset_disp_rs1", 64'(disp_rs1), 64'd0);

    // Three independent ops dispatch back to back in issue order.
    lg.delete();
    for (int i = 0; i < 3; i++) begin
      set_issue(4'(5 + i), 6'(1 + i), 32'(16 + i), 1'b0, 4'd0, 32'(32 + i), 1'b0, 4'd0);
      step(1);
    end
    idle();
    step(4);
    chk("t1_log_size", 64'(lg.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("t1_rob_order", 64'(i < lg.size() ? lg[i].rob : 4'hF), 64'(5 + i));
    if (lg.size() == 3) chk("t1_consecutive", 64'(lg[2].cyc - lg[0].cyc), 64'd2);
    chk("t1_count_end", 64'(rs_count), 64'd0);

    // CDB wakeup on port 1 with producer tag 0; the younger ready op goes first.
    lg.delete();
    set_issue(4'd2, 6'd2, 32'hBAD, 1'b1, 4'd0, 32'h202, 1'b0, 4'd0);
    step(1);
    set_issue(4'd3, 6'd3, 32'h301, 1'b0, 4'd0, 32'h302, 1'b0, 4'd0);
    step(1);
    idle();
    set_cdb(1, 4'd0, 32'hDEAD_BEEF);
    set_cdb(0, 4'd9, 32'h1234);
    step(1);
    t_cdb = cyc;
    idle();
    step(4);
    chk("t2_log_size", 64'(lg.size()), 64'd2);
    if (lg.size() >= 2) begin
      chk("t2_first_rob", 64'(lg[0].rob), 64'd3);
      chk("t2_second_rob", 64'(lg[1].rob), 64'd2);
      chk("t2_second_rs1", 64'(lg[1].rs1), 64'hDEAD_BEEF);
      chk("t2_first_cyc", 64'(lg[0].cyc), 64'(t_cdb));
      chk("t2_second_cyc", 64'(lg[1].cyc), 64'(t_cdb + 1));
    end

    // Two ports hit the same tag: port 0 wins.
    lg.delete();
    set_issue(4'd8, 6'd8, 32'h0, 1'b1, 4'd1, 32'h82, 1'b0, 4'd0);
    step(1);
    idle();
    set_cdb(0, 4'd1, 32'h111);
    set_cdb(1, 4'd1, 32'h222);
    step(1);
    idle();
    step(3);
    chk("lowport_rs1", 64'(lg.size() > 0 ? lg[0].rs1 : 32'hFFFF_FFFF), 64'h111);

    // Wakeup at issue from a same-cycle broadcast.
    lg.delete();
    set_issue(4'd9, 6'd9, 32'h91, 1'b0, 4'd0, 32'hBAD, 1'b1, 4'd4);
    set_cdb(0, 4'd4, 32'h55);
    step(1);
    idle();
    step(1);
    chk("t3_disp_valid", 64'(disp_valid), 64'd1);
    chk("t3_disp_rob", 64'(disp_rob_index), 64'd9);
    chk("t3_disp_rs2", 64'(disp_rs2), 64'h55);
    step(2);

    // Fill under back-pressure, overflow issue ignored, then drain oldest first.
    disp_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_issue(4'(i), 6'(i), 32'(i * 256 + 17), 1'b0, 4'd0, 32'(i), 1'b0, 4'd0);
      step(1);
    end
    chk("t4_full", 64'(rs_full), 64'd1);
    chk("t4_count16", 64'(rs_count), 64'd16);
    set_issue(4'd0, 6'd40, 32'h40, 1'b0, 4'd0, 32'h40, 1'b0, 4'd0);
    step(1);
    idle();
    chk("t4_ignored", 64'(rs_count), 64'd16);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("t4_hold_valid", 64'(disp_valid), 64'd1);
      chk("t4_hold_op", 64'(disp_op), 64'd0);
      chk("t4_hold_rs1", 64'(disp_rs1), 64'h11);
    end
    lg.delete();
    disp_ready = 1'b1;
    step(20);
    chk("t4_drain_size", 64'(lg.size()), 64'd17);
    for (int i = 0; i < 17; i++)
      chk("t4_drain_op", 64'(i < lg.size() ? lg[i].op : 6'h3F), 64'(i));
    chk("t4_count_end", 64'(rs_count), 64'd0);

    // Flush mid-stream discards everything including the concurrent issue.
    lg.delete();
    disp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_issue(4'(i), 6'(50 + i), 32'(i), 1'b0, 4'd0, 32'(i), 1'b0, 4'd0);
      step(1);
    end
    set_issue(4'd5, 6'd55, 32'h5, 1'b0, 4'd0, 32'h5, 1'b0, 4'd0);
    clr_in = 1'b1;
    step(1);
    idle();
    chk("t5_count", 64'(rs_count), 64'd0);
    chk("t5_disp_valid", 64'(disp_valid), 64'd0);
    disp_ready = 1'b1;
    step(3);
    chk("t5_still_empty", 64'(disp_valid), 64'd0);
    chk("t5_no_dispatch", 64'(lg.size()), 64'd0);

    // Same scenario with and without a rdy_in stall must dispatch identically.
    run_scen(1'b0);
    run_scen(1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
